rsa_run_controller: RTL and testbench
=====================================

# rsa_run_controller

Run sequencer for the RSA pipeline CPU. It holds the CPU in reset until a run is requested, then releases reset and drives `start`. While the CPU publishes output bytes (`ReadEnable` strobe, `ReadDataOut`), the block captures them into a byte FIFO and streams them to a downstream consumer over a valid/ready handshake. It reports completion on `EndFlag`, plus overflow and timeout errors. It sits between the CPU core and the board output path inside `top`.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: output FIFO entries; power of 2, at least 2.
- `WDT_CYCLES`, 1_000_000: watchdog limit in RUN state, in clocks. Used only with the watchdog macro.

Ports:
- `clk_FPGA`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `go`  in  1  run request, sampled each cycle; ignored outside IDLE/DONE/ERROR.
- `cpu_rst`  out  1  reset to the CPU core.
- `cpu_start`  out  1  start to the CPU core.
- `cpu_end`  in  1  CPU EndFlag.
- `cpu_com`  in  1  CPU COMFlag; output bytes are qualified by it.
- `cpu_byte_vld`  in  1  CPU ReadEnable strobe, one cycle per byte.
- `cpu_byte`  in  8  CPU ReadDataOut.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts the head.
- `out_data`  out  8  FIFO head byte.
- `busy`  out  1  high in PRIME, RUN and DRAIN.
- `done`  out  1  high in DONE.
- `overflow`  out  1  sticky; a byte was dropped this run.
- `timeout`  out  1  high in ERROR.

## Operation
- States: IDLE, PRIME, RUN, DRAIN, DONE, ERROR.
- IDLE: `cpu_rst`=1, `cpu_start`=0. `go` moves to PRIME.
- DONE and ERROR: same outputs as IDLE. `go` moves to PRIME.
- PRIME (one cycle):
  - `cpu_rst`=0.
  - FIFO flushed.
  - `overflow` and `timeout` cleared, watchdog cleared.
  - Always moves to RUN.
- RUN:
  - `cpu_rst`=0, `cpu_start`=1.
  - Push `cpu_byte` when `cpu_byte_vld && cpu_com`.
  - `cpu_end`=1 moves to DRAIN. A qualified byte in the same cycle as `cpu_end` is still pushed.
- DRAIN:
  - `cpu_rst`=0, `cpu_start`=0.
  - Pushes are ignored.
  - FIFO empty moves to DONE.
- Pop occurs when `out_valid && out_ready`. Pops are allowed in every state except PRIME.
- Full FIFO:
  - A push with no pop in the same cycle is dropped and sets `overflow`. The run continues.
  - A push together with a pop is accepted.
- Empty FIFO: `out_valid`=0 and `out_ready` is ignored.
- FIFO count width is clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values:
  - State IDLE, `cpu_rst`=1, `cpu_start`=0.
  - `out_valid`=0, `out_data`=0.
  - `busy`=`done`=`overflow`=`timeout`=0.
  - FIFO empty, watchdog 0.
- `reset` mid-run: immediate return to IDLE with reset values. Buffered bytes are lost.
- `go` sampled at edge n: PRIME after n, RUN after n+1, so `cpu_start`=1 from edge n+1.
- Capture latency:
  - A byte pushed at edge k into an empty FIFO gives `out_valid`=1 after k.
  - `out_data` is registered FIFO output.
- Handshake:
  - `out_data` holds stable while `out_valid && !out_ready`.
  - Back-to-back pops give one byte per cycle.
- `cpu_end` sampled at edge e: DRAIN after e. DONE the cycle after the FIFO count reaches 0. If the FIFO is already empty at e, DONE is entered after e+1.
- All status outputs are registered and follow the state with no combinational path from inputs.

## Configuration
- Macro `RSA_CTRL_WATCHDOG_EN`.
- Defined:
  - Counter increments each cycle in RUN.
  - Reaching WDT_CYCLES without `cpu_end` moves to ERROR, with `timeout`=1, `cpu_rst`=1 and the FIFO flushed.
  - `cpu_end` in the same cycle as expiry wins and goes to DRAIN.
- Undefined:
  - No counter.
  - `timeout` tied 0.
  - ERROR is unreachable.

## Structure
- Package `rsa_ctrl_pkg` holds:
  - State enum `rsa_ctrl_state_t`.
  - `RSA_BYTE_W`=8.
  - Default `FIFO_DEPTH` and `WDT_CYCLES` constants.
- Sub-module `rsa_byte_fifo`: synchronous FIFO.
  - Ports: push, pop, flush, full, empty, count.
  - Registered head output.
  - Instantiated once.
- FSM, push qualification, overflow and watchdog live in `rsa_run_controller`.

## Test plan
- Reset then `go` pulse, CPU emits 0x41, 0x42, 0x43 with `cpu_com`=1 and `out_ready`=1, then `cpu_end` → out stream is 41,42,43; `done`=1; `cpu_rst` returns to 1.
- `cpu_byte_vld` with `cpu_com`=0 → no push and `out_valid` stays 0.
- `out_ready`=0, 17 bytes with depth 16 → 17th byte dropped, `overflow`=1. Releasing `out_ready` yields exactly 16 bytes, then DONE. A following `go` clears `overflow`.
- Full FIFO, push and pop in the same cycle → both accepted, count stays 16, `overflow`=0.
- `reset` asserted in RUN with 5 bytes buffered → `out_valid`=0, `cpu_rst`=1 and `busy`=0 immediately.
- With `RSA_CTRL_WATCHDOG_EN` and WDT_CYCLES=100, no `cpu_end` → `timeout`=1 after 100 RUN cycles, `cpu_rst`=1; `go` restarts the run.

Source files
------------

// File: rtl/rsa_ctrl_pkg.sv
// Shared types and constants for the RSA run controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rsa_ctrl_pkg;

    localparam int RSA_BYTE_W         = 8;
    localparam int RSA_FIFO_DEPTH_DEF = 16;
    localparam int RSA_WDT_CYCLES_DEF = 1_000_000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } rsa_ctrl_state_t;

    // States in which the CPU core is parked in reset waiting for a run request.
    function automatic logic rsa_is_parked(input rsa_ctrl_state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/rsa_byte_fifo.sv
// Synchronous byte FIFO with a registered head byte and occupancy count.
// Latency: a push into an empty FIFO is visible at the head one clock later.
// Backpressure: push ignored when full unless a pop happens the same cycle; pop ignored when empty.
module rsa_byte_fifo
    import rsa_ctrl_pkg::*;
#(
    parameter int DEPTH = RSA_FIFO_DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [RSA_BYTE_W-1:0] i_wdata,
    input  logic                  i_pop,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [CW-1:0]         o_count,
    output logic [RSA_BYTE_W-1:0] o_rdata
);

    logic [RSA_BYTE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [RSA_BYTE_W-1:0] r_rdata;

    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic [AW-1:0]         w_rd_nxt;
    logic [AW-1:0]         w_wr_nxt;
    logic [CW-1:0]         w_count_nxt;
    logic                  w_head_from_push;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_rdata;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // The new head comes straight from the write port when nothing else remains.
    assign w_head_from_push = o_empty || ((r_count == CW'(1)) && w_pop_ok);

    // Next pointer/count values; pointers wrap naturally at the power-of-2 depth.
    always_comb begin
        w_rd_nxt    = r_rd_ptr;
        w_wr_nxt    = r_wr_ptr;
        w_count_nxt = r_count;
        if (w_pop_ok) begin
            w_rd_nxt = r_rd_ptr + AW'(1);
        end
        if (w_push_ok) begin
            w_wr_nxt = r_wr_ptr + AW'(1);
        end
        if (w_push_ok && !w_pop_ok) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop_ok && !w_push_ok) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Storage array; no reset needed since occupancy is tracked by the count.
    always_ff @(posedge i_clk) begin
        if (w_push_ok && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy registers; flush empties the FIFO in one clock.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // Registered head byte; held while the head is not popped.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (!i_flush && (w_count_nxt != '0)) begin
            if (w_head_from_push) begin
                r_rdata <= i_wdata;
            end else begin
                r_rdata <= r_mem[w_rd_nxt];
            end
        end
    end

endmodule

// File: rtl/rsa_run_controller.sv
// Run sequencer: parks the CPU in reset, starts a run, buffers its output bytes and reports completion.
// Latency: go -> cpu_start two clocks; captured byte -> out_valid one clock; all status outputs registered.
// Backpressure: out_valid/out_ready on the byte stream; a push into a full FIFO without a pop is dropped and flagged.
// Optional watchdog on the RUN state is enabled by defining RSA_CTRL_WATCHDOG_EN.
module rsa_run_controller
    import rsa_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = RSA_FIFO_DEPTH_DEF,
    parameter int WDT_CYCLES = RSA_WDT_CYCLES_DEF
) (
    input  logic                  clk_FPGA,
    input  logic                  reset,
    input  logic                  go,
    output logic                  cpu_rst,
    output logic                  cpu_start,
    input  logic                  cpu_end,
    input  logic                  cpu_com,
    input  logic                  cpu_byte_vld,
    input  logic [RSA_BYTE_W-1:0] cpu_byte,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RSA_BYTE_W-1:0] out_data,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  timeout
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rsa_ctrl_state_t       r_state;
    rsa_ctrl_state_t       w_state_nxt;

    logic                  r_cpu_rst;
    logic                  r_cpu_start;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_overflow;
    logic                  r_timeout;

    logic                  w_push_req;
    logic                  w_pop_req;
    logic                  w_drop;
    logic                  w_flush;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wdt_expire;
    logic                  w_to_error;
    logic [CW-1:0]         w_fifo_count_unused;
    logic [RSA_BYTE_W-1:0] w_head;

    // Only qualified bytes during RUN are captured; DRAIN ignores the CPU.
    assign w_push_req = (r_state == ST_RUN) && cpu_byte_vld && cpu_com;
    // The consumer may drain in any state except the flush cycle.
    assign w_pop_req  = !w_empty && out_ready && (r_state != ST_PRIME);
    assign w_to_error = (r_state == ST_RUN) && w_wdt_expire && !cpu_end;
    assign w_flush    = (r_state == ST_PRIME) || w_to_error;
    assign w_drop     = w_push_req && w_full && !w_pop_req && !w_flush;

`ifdef RSA_CTRL_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);

    logic [WDT_W-1:0] r_wdt;

    assign w_wdt_expire = (r_state == ST_RUN) && (r_wdt == WDT_W'(WDT_CYCLES - 1));

    // Counts RUN cycles; restarted by every new run.
    always_ff @(posedge clk_FPGA or posedge reset) begin
        if (reset) begin
            r_wdt <= '0;
        end else if (r_state == ST_PRIME) begin
            r_wdt <= '0;
        end else if ((r_state == ST_RUN) && !w_wdt_expire) begin
            r_wdt <= r_wdt + WDT_W'(1);
        end
    end
`else
    logic w_wdt_unused;

    assign w_wdt_expire = 1'b0;
    assign w_wdt_unused = (WDT_CYCLES == 0);
`endif

    rsa_byte_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_FPGA),
        .i_rst   (reset),
        .i_flush (w_flush),
        .i_push  (w_push_req),
        .i_wdata (cpu_byte),
        .i_pop   (w_pop_req),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_count_unused),
        .o_rdata (w_head)
    );

    // State register.
    always_ff @(posedge clk_FPGA or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; cpu_end wins over a simultaneous watchdog expiry.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (go) begin
                    w_state_nxt = ST_PRIME;
                end
            end
            ST_PRIME: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (cpu_end) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_wdt_expire) begin
                    w_state_nxt = ST_ERROR;
                end
            end
            ST_DRAIN: begin
                if (w_empty) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Status outputs registered from the next state so they line up with r_state.
    always_ff @(posedge clk_FPGA or posedge reset) begin
        if (reset) begin
            r_cpu_rst   <= 1'b1;
            r_cpu_start <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_cpu_rst   <= rsa_is_parked(w_state_nxt);
            r_cpu_start <= (w_state_nxt == ST_RUN);
            r_busy      <= (w_state_nxt == ST_PRIME) || (w_state_nxt == ST_RUN) ||
                           (w_state_nxt == ST_DRAIN);
            r_done      <= (w_state_nxt == ST_DONE);
`ifdef RSA_CTRL_WATCHDOG_EN
            r_timeout   <= (w_state_nxt == ST_ERROR);
`else
            r_timeout   <= 1'b0;
`endif
        end
    end

    // Sticky drop flag, cleared as a new run is primed.
    always_ff @(posedge clk_FPGA or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_state_nxt == ST_PRIME) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign cpu_rst   = r_cpu_rst;
    assign cpu_start = r_cpu_start;
    assign busy      = r_busy;
    assign done      = r_done;
    assign overflow  = r_overflow;
    assign timeout   = r_timeout;
    assign out_valid = !w_empty;
    assign out_data  = w_head;

endmodule

// File: tb/tb_rsa_run_controller.sv
module tb_rsa_run_controller;

    logic       clk_FPGA = 1'b0;
    logic       reset;
    logic       go;
    logic       cpu_rst;
    logic       cpu_start;
    logic       cpu_end;
    logic       cpu_com;
    logic       cpu_byte_vld;
    logic [7:0] cpu_byte;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
    logic       done;
    logic       overflow;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk_FPGA = ~clk_FPGA;

    rsa_run_controller #(
        .FIFO_DEPTH   (16),
        .WDT_CYCLES   (100)
    ) dut (
        .clk_FPGA     (clk_FPGA),
        .reset        (reset),
        .go           (go),
        .cpu_rst      (cpu_rst),
        .cpu_start    (cpu_start),
        .cpu_end      (cpu_end),
        .cpu_com      (cpu_com),
        .cpu_byte_vld (cpu_byte_vld),
        .cpu_byte     (cpu_byte),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .timeout      (timeout)
    );

    typedef struct {
        logic       go;
        logic       cend;
        logic       com;
        logic       bvld;
        logic [7:0] byt;
        logic       rdy;
        logic       e_rst;
        logic       e_start;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_busy;
        logic       e_done;
        logic       e_ovf;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic g, input logic ce, input logic cm, input logic bv,
                                input logic [7:0] b, input logic rd,
                                input logic er, input logic es, input logic ev, input logic [7:0] ed,
                                input logic eb, input logic edn, input logic eo);
        vec_t v;
        v.go = g; v.cend = ce; v.com = cm; v.bvld = bv; v.byt = b; v.rdy = rd;
        v.e_rst = er; v.e_start = es; v.e_valid = ev; v.e_data = ed;
        v.e_busy = eb; v.e_done = edn; v.e_ovf = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_FPGA);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic rdy);
        cpu_byte_vld = 1'b1;
        cpu_com      = 1'b1;
        cpu_byte     = b;
        out_ready    = rdy;
        step();
        cpu_byte_vld = 1'b0;
        cpu_com      = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        chk(name, done, 1);
    endtask

    task automatic start_run();
        go = 1'b1;
        step();
        go = 1'b0;
        chk("prime_busy", busy, 1);
        chk("prime_ovf_clr", overflow, 0);
        step();
        chk("run_start", cpu_start, 1);
    endtask

    initial begin
        reset        = 1'b1;
        go           = 1'b0;
        cpu_end      = 1'b0;
        cpu_com      = 1'b0;
        cpu_byte_vld = 1'b0;
        cpu_byte     = 8'h00;
        out_ready    = 1'b0;

        //           go ce cm bv byte   rd  rst st vl data  by dn ov
        vecs[0]  = mk(1, 0, 0, 0, 8'h00, 0,  0, 0, 0, 8'h00, 1, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 8'h00, 0,  0, 1, 0, 8'h00, 1, 0, 0);
        vecs[2]  = mk(0, 0, 1, 1, 8'h41, 1,  0, 1, 1, 8'h41, 1, 0, 0);
        vecs[3]  = mk(0, 0, 1, 1, 8'h42, 1,  0, 1, 1, 8'h42, 1, 0, 0);
        vecs[4]  = mk(0, 0, 1, 1, 8'h43, 1,  0, 1, 1, 8'h43, 1, 0, 0);
        vecs[5]  = mk(0, 1, 0, 0, 8'h00, 1,  0, 0, 0, 8'h00, 1, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 8'h00, 1,  1, 0, 0, 8'h00, 0, 1, 0);
        vecs[7]  = mk(0, 0, 1, 1, 8'h55, 1,  1, 0, 0, 8'h00, 0, 1, 0);
        vecs[8]  = mk(1, 0, 0, 0, 8'h00, 1,  0, 0, 0, 8'h00, 1, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 8'h00, 1,  0, 1, 0, 8'h00, 1, 0, 0);
        vecs[10] = mk(1, 0, 0, 1, 8'h99, 1,  0, 1, 0, 8'h00, 1, 0, 0);
        vecs[11] = mk(0, 0, 0, 1, 8'hAA, 0,  0, 1, 0, 8'h00, 1, 0, 0);
        vecs[12] = mk(0, 1, 0, 0, 8'h00, 0,  0, 0, 0, 8'h00, 1, 0, 0);
        vecs[13] = mk(0, 0, 0, 0, 8'h00, 0,  1, 0, 0, 8'h00, 0, 1, 0);

        // Reset values, while reset is held and after release.
        step();
        step();
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_cpu_start", cpu_start, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_timeout", timeout, 0);
        reset = 1'b0;
        step();
        chk("idle_cpu_rst", cpu_rst, 1);
        chk("idle_busy", busy, 0);

        // Table: a basic 3-byte run, then a run with unqualified bytes only.
        for (int i = 0; i < 14; i++) begin
            go           = vecs[i].go;
            cpu_end      = vecs[i].cend;
            cpu_com      = vecs[i].com;
            cpu_byte_vld = vecs[i].bvld;
            cpu_byte     = vecs[i].byt;
            out_ready    = vecs[i].rdy;
            step();
            chk($sformatf("v%0d_cpu_rst", i), cpu_rst, vecs[i].e_rst);
            chk($sformatf("v%0d_cpu_start", i), cpu_start, vecs[i].e_start);
            chk($sformatf("v%0d_valid", i), out_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_data", i), out_data, vecs[i].e_data);
            end
            chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("v%0d_done", i), done, vecs[i].e_done);
            chk($sformatf("v%0d_ovf", i), overflow, vecs[i].e_ovf);
            chk($sformatf("v%0d_timeout", i), timeout, 0);
        end
        go           = 1'b0;
        cpu_end      = 1'b0;
        cpu_com      = 1'b0;
        cpu_byte_vld = 1'b0;
        out_ready    = 1'b0;

        // Overflow: 17 bytes into a 16-deep FIFO with the consumer stalled.
        start_run();
        for (int i = 0; i < 17; i++) begin
            push_byte(8'(8'h10 + i), 1'b0);
            if (i == 15) begin
                chk("ovf_at_16", overflow, 0);
            end
        end
        chk("ovf_at_17", overflow, 1);
        chk("ovf_head", out_data, 8'h10);
        cpu_end = 1'b1;
        step();
        cpu_end = 1'b0;
        chk("ovf_drain_busy", busy, 1);
        chk("ovf_drain_start", cpu_start, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf_pop%0d_valid", i), out_valid, 1);
            chk($sformatf("ovf_pop%0d_data", i), out_data, 8'(8'h10 + i));
            step();
        end
        wait_done("ovf_done");
        chk("ovf_empty_after", out_valid, 0);
        chk("ovf_sticky", overflow, 1);
        out_ready = 1'b0;

        // Full FIFO with simultaneous push and pop: both accepted.
        start_run();
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(8'h60 + i), 1'b0);
        end
        chk("full_head", out_data, 8'h60);
        chk("full_ovf", overflow, 0);
        push_byte(8'h70, 1'b1);
        out_ready = 1'b0;
        chk("pp_ovf", overflow, 0);
        chk("pp_head", out_data, 8'h61);
        step();
        chk("hold_head", out_data, 8'h61);
        cpu_end = 1'b1;
        step();
        cpu_end   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("pp_pop%0d_valid", i), out_valid, 1);
            chk($sformatf("pp_pop%0d_data", i), out_data, (i < 15) ? 8'(8'h61 + i) : 8'h70);
            step();
        end
        wait_done("pp_done");
        chk("pp_empty_after", out_valid, 0);
        out_ready = 1'b0;

        // Asynchronous reset in RUN with 5 bytes buffered.
        start_run();
        for (int i = 0; i < 5; i++) begin
            push_byte(8'(8'hA0 + i), 1'b0);
        end
        chk("mid_valid", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_cpu_rst", cpu_rst, 1);
        chk("arst_busy", busy, 0);
        chk("arst_start", cpu_start, 0);
        step();
        reset = 1'b0;
        step();
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_done", done, 0);
        chk("post_rst_cpu_rst", cpu_rst, 1);

`ifdef RSA_CTRL_WATCHDOG_EN
        // Watchdog expiry after 100 RUN cycles without cpu_end.
        begin
            int n;
            start_run();
            n = 0;
            while (!timeout && n < 300) begin
                step();
                n++;
            end
            chk("wdt_cycles", n, 100);
            chk("wdt_timeout", timeout, 1);
            chk("wdt_cpu_rst", cpu_rst, 1);
            chk("wdt_busy", busy, 0);
            chk("wdt_valid", out_valid, 0);
            go = 1'b1;
            step();
            go = 1'b0;
            chk("wdt_restart_timeout", timeout, 0);
            chk("wdt_restart_busy", busy, 1);
            step();
            cpu_end = 1'b1;
            step();
            cpu_end = 1'b0;
            wait_done("wdt_restart_done");
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
